// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch and the MEM-stage load/store path.
// Data normally wins; a starvation counter forces fetches through, and a hold buffer parks fetch data while IF/ID is frozen.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4,
  parameter int unsigned STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               inst_req,
  input  logic [31:0]        inst_addr,
  output logic               inst_gnt,
  output logic               inst_rvalid,
  output logic [31:0]        inst_rdata,
  input  logic               data_req,
  input  logic [3:0]         data_wen,
  input  logic [31:0]        data_addr,
  input  logic [31:0]        data_wdata,
  output logic               data_gnt,
  output logic               data_rvalid,
  output logic [31:0]        data_rdata,
  output logic               sram_en,
  output logic [3:0]         sram_wen,
  output logic [31:0]        sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               stallreq_inst,
  output logic               stallreq_data
);

  localparam int unsigned CNT_W = 4;
  localparam logic        STOP  = 1'b1;

  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_e;

  owner_e             owner_q, owner_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic               hold_valid_q, hold_valid_d;
  logic [31:0]        hold_data_q, hold_data_d;
  logic               boot_q;

  logic active;
  logic if_stop;
  logic capture;
  logic hold_now;
  logic inst_ok;
  logic force_inst;

  logic unused_stall;
  assign unused_stall = ^stall;

  // State registers; boot_q blanks every output in the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      run_cnt_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      boot_q       <= 1'b1;
    end else begin
      owner_q      <= owner_d;
      run_cnt_q    <= run_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      boot_q       <= 1'b0;
    end
  end

  // Arbitration, SRAM bus, responses and next state.
  always_comb begin
    inst_gnt      = 1'b0;
    data_gnt      = 1'b0;
    inst_rvalid   = 1'b0;
    inst_rdata    = '0;
    data_rvalid   = 1'b0;
    data_rdata    = '0;
    sram_en       = 1'b0;
    sram_wen      = '0;
    sram_addr     = '0;
    sram_wdata    = '0;
    stallreq_inst = 1'b0;
    stallreq_data = 1'b0;
    owner_d       = OWN_NONE;
    run_cnt_d     = '0;
    hold_valid_d  = hold_valid_q;
    hold_data_d   = hold_data_q;

    active     = ~rst & ~boot_q;
    if_stop    = (stall[1] == STOP);
    // The capture cycle already counts as held, so no second fetch can be issued behind it.
    capture    = (owner_q == OWN_INST) & if_stop;
    hold_now   = hold_valid_q | capture;
    inst_ok    = active & inst_req & ~hold_now;
    force_inst = inst_ok & (run_cnt_q == CNT_W'(MAX_DATA_RUN));
    data_gnt   = active & data_req & ~force_inst;
    inst_gnt   = inst_ok & ~data_gnt;

    if (data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end

    if (active) begin
      if (owner_q == OWN_DATA) begin
        data_rvalid = 1'b1;
        data_rdata  = sram_rdata;
      end
      if (hold_valid_q) begin
        inst_rvalid = 1'b1;
        inst_rdata  = hold_data_q;
      end else if (owner_q == OWN_INST) begin
        inst_rvalid = 1'b1;
        inst_rdata  = sram_rdata;
      end
    end

    stallreq_inst = active & inst_req & ~inst_gnt;
    stallreq_data = active & data_req & ~data_gnt;

    if (inst_gnt)
      owner_d = OWN_INST;
    else if (data_gnt && data_wen == 4'b0000)
      owner_d = OWN_DATA;

    if (data_gnt && inst_ok)
      run_cnt_d = (run_cnt_q == CNT_W'(MAX_DATA_RUN)) ? run_cnt_q : run_cnt_q + CNT_W'(1);

    if (capture) begin
      hold_valid_d = 1'b1;
      hold_data_d  = sram_rdata;
    end else if (hold_valid_q && !if_stop) begin
      hold_valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small one-cycle-latency SRAM model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        stallreq_inst;
  logic        stallreq_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  localparam logic [5:0] STOP_V = 6'b000010;

  mem_port_arbiter #(.MAX_DATA_RUN(4), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .stallreq_inst(stallreq_inst), .stallreq_data(stallreq_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: reads return one cycle after issue, writes update byte lanes.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen == 4'b0000)
        sram_rdata <= mem[sram_addr[9:2]];
      else
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) mem[sram_addr[9:2]][8*b +: 8] = sram_wdata[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req   = 1'b0;
    inst_addr  = '0;
    data_req   = 1'b0;
    data_wen   = '0;
    data_addr  = '0;
    data_wdata = '0;
    stall      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h100; data_addr = 32'h20;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({inst_gnt, data_gnt, inst_rvalid, data_rvalid, sram_en, stallreq_inst, stallreq_data} !== 7'b0 ||
        sram_addr !== 32'h0 || inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: gnt=%b/%b en=%b sreq=%b/%b addr=%h, required all 0",
                         inst_gnt, data_gnt, sram_en, stallreq_inst, stallreq_data, sram_addr);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({inst_gnt, data_gnt, inst_rvalid, data_rvalid, sram_en, stallreq_inst, stallreq_data} !== 7'b0) begin
      n_fail++; $display("FAIL reset_first_cycle: gnt=%b/%b rv=%b/%b en=%b sreq=%b/%b, required all 0",
                         inst_gnt, data_gnt, inst_rvalid, data_rvalid, sram_en, stallreq_inst, stallreq_data);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (inst_rvalid !== 1'b0 || data_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_rvalid: inst_rvalid=%b data_rvalid=%b, required 0 0", inst_rvalid, data_rvalid);
    end
    tick();
  endtask

  task automatic test_solo_fetch();
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    @(negedge clk);
    n_checks++;
    if (inst_gnt !== 1'b1 || sram_en !== 1'b1 || sram_addr !== 32'h100 || sram_wen !== 4'b0 || stallreq_inst !== 1'b0) begin
      n_fail++; $display("FAIL solo_fetch_issue: gnt=%b en=%b addr=%h wen=%b sreq=%b, required 1 1 00000100 0000 0",
                         inst_gnt, sram_en, sram_addr, sram_wen, stallreq_inst);
    end
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h2408_0001) begin
      n_fail++; $display("FAIL solo_fetch_resp: rvalid=%b rdata=%h, required 1 24080001", inst_rvalid, inst_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [5:0] exp_dg, exp_ig, exp_drv, exp_irv;
    exp_dg  = 6'b101111;
    exp_ig  = 6'b010000;
    exp_drv = 6'b011110;
    exp_irv = 6'b100000;
    data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h20;
    inst_req = 1'b1; inst_addr = 32'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (data_gnt !== exp_dg[c] || inst_gnt !== exp_ig[c] ||
          stallreq_inst !== exp_dg[c] || stallreq_data !== exp_ig[c]) begin
        n_fail++; $display("FAIL contention_grant c%0d: dgnt=%b ignt=%b sreq_i=%b sreq_d=%b, required %b %b %b %b",
                           c, data_gnt, inst_gnt, stallreq_inst, stallreq_data, exp_dg[c], exp_ig[c], exp_dg[c], exp_ig[c]);
      end
      n_checks++;
      if (data_rvalid !== exp_drv[c] || inst_rvalid !== exp_irv[c] ||
          (exp_drv[c] && data_rdata !== 32'hCAFE_0008) || (exp_irv[c] && inst_rdata !== 32'h0000_AAAA)) begin
        n_fail++; $display("FAIL contention_resp c%0d: drv=%b drdata=%h irv=%b irdata=%h, required %b CAFE0008 %b 0000AAAA",
                           c, data_rvalid, data_rdata, inst_rvalid, inst_rdata, exp_drv[c], exp_irv[c]);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (data_rvalid !== 1'b1 || data_rdata !== 32'hCAFE_0008 || inst_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL contention_tail: drv=%b drdata=%h irv=%b, required 1 CAFE0008 0", data_rvalid, data_rdata, inst_rvalid);
    end
    tick();
  endtask

  task automatic test_store();
    data_req = 1'b1; data_wen = 4'b0100; data_addr = 32'h10; data_wdata = 32'h00AB_0000;
    @(negedge clk);
    n_checks++;
    if (data_gnt !== 1'b1 || sram_en !== 1'b1 || sram_wen !== 4'b0100 || sram_addr !== 32'h10 || sram_wdata !== 32'h00AB_0000) begin
      n_fail++; $display("FAIL store_issue: gnt=%b en=%b wen=%b addr=%h wdata=%h, required 1 1 0100 00000010 00AB0000",
                         data_gnt, sram_en, sram_wen, sram_addr, sram_wdata);
    end
    tick();
    data_req = 1'b1; data_wen = 4'b0000; data_wdata = '0;
    @(negedge clk);
    n_checks++;
    if (data_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL store_no_resp: data_rvalid=%b, required 0", data_rvalid);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (data_rvalid !== 1'b1 || data_rdata !== 32'h11AB_3344) begin
      n_fail++; $display("FAIL store_readback: rvalid=%b rdata=%h, required 1 11AB3344", data_rvalid, data_rdata);
    end
    tick();
  endtask

  task automatic test_hold_buffer();
    inst_req = 1'b1; inst_addr = 32'h80;
    @(negedge clk);
    n_checks++;
    if (inst_gnt !== 1'b1) begin
      n_fail++; $display("FAIL hold_issue: inst_gnt=%b, required 1", inst_gnt);
    end
    tick();
    inst_addr = 32'h84;
    for (int c = 1; c <= 4; c++) begin
      stall    = (c <= 3) ? STOP_V : 6'b0;
      data_req = (c == 2);
      data_addr = 32'h30;
      @(negedge clk);
      n_checks++;
      if (inst_rvalid !== 1'b1 || inst_rdata !== 32'hDEAD_BEEF || inst_gnt !== 1'b0 || stallreq_inst !== 1'b1) begin
        n_fail++; $display("FAIL hold_cycle c%0d: rvalid=%b rdata=%h gnt=%b sreq=%b, required 1 DEADBEEF 0 1",
                           c, inst_rvalid, inst_rdata, inst_gnt, stallreq_inst);
      end
      if (c == 3) begin
        n_checks++;
        if (data_rvalid !== 1'b1 || data_rdata !== 32'h5555_000C) begin
          n_fail++; $display("FAIL hold_data_side: rvalid=%b rdata=%h, required 1 5555000C", data_rvalid, data_rdata);
        end
      end
      tick();
    end
    data_req = 1'b0; stall = '0;
    @(negedge clk);
    n_checks++;
    if (inst_gnt !== 1'b1 || inst_rvalid !== 1'b0 || sram_addr !== 32'h84) begin
      n_fail++; $display("FAIL hold_release_gnt: gnt=%b rvalid=%b addr=%h, required 1 0 00000084", inst_gnt, inst_rvalid, sram_addr);
    end
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 32'hA500_0021) begin
      n_fail++; $display("FAIL hold_next_fetch: rvalid=%b rdata=%h, required 1 A5000021", inst_rvalid, inst_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    inst_req = 1'b1; inst_addr = 32'h0;
    @(negedge clk);
    n_checks++;
    if (inst_gnt !== 1'b1) begin
      n_fail++; $display("FAIL b2b_inst_issue: inst_gnt=%b, required 1", inst_gnt);
    end
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h4;
    @(negedge clk);
    n_checks++;
    if (data_gnt !== 1'b1 || inst_rvalid !== 1'b1 || inst_rdata !== 32'h0000_AAAA || data_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_cycle1: dgnt=%b irv=%b irdata=%h drv=%b, required 1 1 0000AAAA 0",
                         data_gnt, inst_rvalid, inst_rdata, data_rvalid);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (data_rvalid !== 1'b1 || data_rdata !== 32'h0000_BBBB || inst_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_cycle2: drv=%b drdata=%h irv=%b, required 1 0000BBBB 0", data_rvalid, data_rdata, inst_rvalid);
    end
    n_checks++;
    if (sram_en !== 1'b0 || sram_addr !== 32'h0 || sram_wdata !== 32'h0 || sram_wen !== 4'b0) begin
      n_fail++; $display("FAIL idle_bus: en=%b addr=%h wdata=%h wen=%b, required 0 0 0 0", sram_en, sram_addr, sram_wdata, sram_wen);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    data_req = 1'b1; data_addr = 32'h20;
    @(negedge clk);
    n_checks++;
    if (data_gnt !== 1'b1) begin
      n_fail++; $display("FAIL midreset_issue: data_gnt=%b, required 1", data_gnt);
    end
    tick();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (data_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_in_reset: data_rvalid=%b, required 0", data_rvalid);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (data_rvalid !== 1'b0 || inst_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL midreset_after c%0d: drv=%b irv=%b, required 0 0", c, data_rvalid, inst_rvalid);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[0]  = 32'h0000_AAAA;
    mem[1]  = 32'h0000_BBBB;
    mem[4]  = 32'h1122_3344;
    mem[8]  = 32'hCAFE_0008;
    mem[12] = 32'h5555_000C;
    mem[32] = 32'hDEAD_BEEF;
    mem[64] = 32'h2408_0001;
    sram_rdata = '0;
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_solo_fetch();
    test_contention();
    test_store();
    test_hold_buffer();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-port data SRAM between instruction fetch (IF) and the MEM-stage load/store path.
- Issues at most one SRAM access per cycle, with data requests normally winning.
- A starvation counter guarantees fetch progress, and an instruction hold buffer keeps returned fetch data while IF/ID is frozen.
- Raises per-requester stall requests toward the pipeline stall controller.

## Interface
Parameters:
- `MAX_DATA_RUN`, default 4: consecutive data grants allowed while a fetch is waiting before the fetch is forced through. Range 1–15.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  `StallBus`  pipeline stall vector; `stall[1]==Stop` means IF/ID is frozen
- `inst_req`  in  1  fetch request (read)
- `inst_addr`  in  32  fetch byte address
- `inst_gnt`  out  1  fetch accepted this cycle
- `inst_rvalid`  out  1  fetch data valid
- `inst_rdata`  out  32  fetch data
- `data_req`  in  1  MEM access request
- `data_wen`  in  4  byte write enables; `4'b0000` means read
- `data_addr`  in  32  data byte address
- `data_wdata`  in  32  store data, already lane-aligned
- `data_gnt`  out  1  data access accepted this cycle
- `data_rvalid`  out  1  load data valid
- `data_rdata`  out  32  raw load word; extension and lane select are done downstream
- `sram_en`  out  1  SRAM enable
- `sram_wen`  out  4  SRAM byte write enables
- `sram_addr`  out  32  SRAM address
- `sram_wdata`  out  32  SRAM write data
- `sram_rdata`  in  32  SRAM read data, valid one cycle after a read issue
- `stallreq_inst`  out  1  fetch cannot proceed
- `stallreq_data`  out  1  data access cannot proceed

## Operation
Arbitration is combinational each cycle:
- `inst_ok = inst_req & ~hold_valid`.
- `force_inst = inst_ok & (run_cnt == MAX_DATA_RUN)`.
- `data_gnt = data_req & ~force_inst`.
- `inst_gnt = inst_ok & ~data_gnt`.
- The SRAM bus is driven from the granted requester. With no grant: `sram_en=0`, `sram_wen=0`, `sram_addr=0`, `sram_wdata=0`.
- An inst grant always drives `sram_wen=4'b0000`.

Starvation counter `run_cnt` (4 bits):
- Cleared when `inst_gnt` or `~inst_ok`.
- Incremented when `data_gnt & inst_ok`.
- Saturates at `MAX_DATA_RUN`.

Response owner register `owner ∈ {NONE, INST, DATA}`, updated every cycle:
- Becomes INST on `inst_gnt`.
- Becomes DATA on a data read grant (`data_gnt & data_wen==0`).
- Becomes NONE otherwise, including all writes.

Response, in the cycle after the issue:
- `owner==DATA`: `data_rvalid=1`, `data_rdata=sram_rdata`.
- `owner==INST` and `stall[1]!=Stop`: `inst_rvalid=1`, `inst_rdata=sram_rdata`.
- `owner==INST` and `stall[1]==Stop`: capture `sram_rdata` into `hold_data` and set `hold_valid=1`.

Hold buffer:
- While `hold_valid`, `inst_rvalid=1` and `inst_rdata=hold_data`.
- `hold_valid` clears on the first cycle with `stall[1]!=Stop`, which is the consuming cycle.
- No new fetch is granted while `hold_valid`, so there is never a second outstanding fetch.

Stall requests:
- `stallreq_inst = inst_req & ~inst_gnt`.
- `stallreq_data = data_req & ~data_gnt`.

## Timing
- Reset: `run_cnt=0`, `owner=NONE`, `hold_valid=0`, `hold_data=0`.
  - All outputs are 0 while `rst` is high and in the first cycle after it.
  - Reset mid-read discards the response; no `rvalid` follows.
- Grant to `rvalid` latency is exactly 1 cycle.
- Writes complete at grant and produce no response.
- Back-to-back grants are allowed every cycle, including read-then-read to different owners.
  - Each `rvalid` follows its own issue by exactly 1 cycle.
- Simultaneous `data_req` and `inst_req` with `run_cnt<MAX_DATA_RUN`: data wins.
- At `run_cnt==MAX_DATA_RUN`: inst wins for one cycle and `run_cnt` clears.
- `stall[1]` changing in the capture cycle: the value sampled in that cycle decides direct pass-through versus capture.
- Requesters hold `req`, `addr`, `wen` and `wdata` stable until they see their `gnt`.

## Test plan
- Reset: assert `rst` with both requests high → all outputs 0. Next cycle `owner=NONE` and no `rvalid`.
- Solo fetch: `inst_req=1`, `inst_addr=0x0000_0100`, SRAM returns `0x2408_0001` → `inst_gnt` in cycle 0, `inst_rvalid=1` with `inst_rdata=0x2408_0001` in cycle 1, `stallreq_inst=0`.
- Contention, `MAX_DATA_RUN=4`: `data_req` held high for 6 read cycles, `inst_req` high throughout → `data_gnt` in cycles 0–3, `inst_gnt` in cycle 4, `data_gnt` in cycle 5. `stallreq_inst=1` in cycles 0–3 and 5; `stallreq_data=1` in cycle 4.
- Store: `data_wen=4'b0100`, `data_addr=0x10`, `data_wdata=0x00AB_0000` → `sram_wen=4'b0100` with the same address and data in cycle 0. No `data_rvalid` in cycle 1.
- Hold buffer: fetch returns `0xDEAD_BEEF` with `stall[1]=Stop` for 3 cycles, `inst_req` kept high → `inst_rvalid=1` with `0xDEAD_BEEF` in all 3 cycles and the release cycle. No `inst_gnt` until the cycle after release.
- Mixed ownership: inst read at `0x0` then data read at `0x4` on consecutive cycles → `inst_rvalid` in cycle 1, `data_rvalid` in cycle 2, each carrying its own word.
